// File: rtl/l2_refill_pkg.sv
// Shared types, default widths and helpers for the L2 refill controller.
package l2_refill_pkg;

  localparam int INDEX_BITS = 7;
  localparam int TAG_BITS   = 4;
  localparam int WAY_BITS   = 3;
  localparam int BLOCK_BITS = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_RD,
    S_FILL,
    S_DONE
  } state_t;

  // Memory line address is the tag placed directly above the set index.
  function automatic logic [TAG_BITS+INDEX_BITS-1:0] line_addr(
    input logic [TAG_BITS-1:0]   tag,
    input logic [INDEX_BITS-1:0] index
  );
    return {tag, index};
  endfunction

endpackage

// File: rtl/l2_refill_arb.sv
// Two-port round-robin arbiter; priority passes to the port not granted.
module l2_refill_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_p1,
  input  logic req_p2,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_p2
);

  logic prio_p2;

  assign grant_valid = req_p1 | req_p2;
  assign grant_p2    = req_p2 & (~req_p1 | prio_p2);

  // Flip priority to the loser each time a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_p2 <= 1'b0;
    end else if (grant_en && grant_valid) begin
      prio_p2 <= ~grant_p2;
    end
  end

endmodule

// File: rtl/l2_refill_ctrl.sv
// L2 miss/refill controller: arbitrate, write back dirty victim, read line, install.
module l2_refill_ctrl
  import l2_refill_pkg::*;
#(
  parameter int index_bits         = INDEX_BITS,
  parameter int tag_bits           = TAG_BITS,
  parameter int no_of_l2_ways_bits = WAY_BITS,
  parameter int block_bits         = BLOCK_BITS
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            miss_L2_p1,
  input  logic                            miss_L2_p2,
  input  logic [index_bits-1:0]           index_1_to_L2,
  input  logic [index_bits-1:0]           index_2_to_L2,
  input  logic [tag_bits-1:0]             tag_1_to_L2,
  input  logic [tag_bits-1:0]             tag_2_to_L2,
  input  logic [no_of_l2_ways_bits-1:0]   LRU_block_L2_1,
  input  logic [no_of_l2_ways_bits-1:0]   LRU_block_L2_2,
  output logic [index_bits-1:0]           lookup_index,
  output logic [no_of_l2_ways_bits-1:0]   lookup_way,
  input  logic                            victim_valid,
  input  logic                            victim_dirty,
  input  logic [tag_bits-1:0]             victim_tag,
  input  logic [block_bits-1:0]           victim_data,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [tag_bits+index_bits-1:0]  mem_addr,
  output logic [block_bits-1:0]           mem_wdata,
  input  logic                            mem_ack,
  input  logic [block_bits-1:0]           mem_rdata,
  output logic                            fill_en,
  output logic [index_bits-1:0]           fill_index,
  output logic [no_of_l2_ways_bits-1:0]   fill_way,
  output logic [tag_bits-1:0]             fill_tag,
  output logic [block_bits-1:0]           fill_data,
  output logic                            refill_done_p1,
  output logic                            refill_done_p2,
  output logic                            busy
);

  state_t                          state, next_state;
  logic                            grant_valid, grant_p2;
  logic                            owner_p2;
  logic [index_bits-1:0]           index_q;
  logic [tag_bits-1:0]             tag_q;
  logic [no_of_l2_ways_bits-1:0]   way_q;
  logic [tag_bits-1:0]             vtag_q;
  logic [block_bits-1:0]           vdata_q;
  logic [block_bits-1:0]           rdata_q;

  l2_refill_arb u_arb (
    .clk         (CLK),
    .rst_n       (RST),
    .req_p1      (miss_L2_p1),
    .req_p2      (miss_L2_p2),
    .grant_en    (state == S_IDLE),
    .grant_valid (grant_valid),
    .grant_p2    (grant_p2)
  );

  // State register; reset abandons any memory transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request latched at grant, victim snapshot at lookup, read data at ack.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner_p2 <= 1'b0;
      index_q  <= '0;
      tag_q    <= '0;
      way_q    <= '0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            owner_p2 <= grant_p2;
            index_q  <= grant_p2 ? index_2_to_L2  : index_1_to_L2;
            tag_q    <= grant_p2 ? tag_2_to_L2    : tag_1_to_L2;
            way_q    <= grant_p2 ? LRU_block_L2_2 : LRU_block_L2_1;
          end
        end
        S_LOOKUP: begin
          vtag_q  <= victim_tag;
          vdata_q <= victim_data;
        end
        S_RD: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; memory outputs only live in WB and RD.
  always_comb begin
    next_state     = state;
    lookup_index   = index_q;
    lookup_way     = way_q;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    fill_en        = 1'b0;
    fill_index     = index_q;
    fill_way       = way_q;
    fill_tag       = tag_q;
    fill_data      = rdata_q;
    refill_done_p1 = 1'b0;
    refill_done_p2 = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (grant_valid) next_state = S_LOOKUP;
      end
      S_LOOKUP: begin
        next_state = (victim_valid && victim_dirty) ? S_WB : S_RD;
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = line_addr(vtag_q, index_q);
        mem_wdata = vdata_q;
        if (mem_ack) next_state = S_RD;
      end
      S_RD: begin
        mem_req  = 1'b1;
        mem_addr = line_addr(tag_q, index_q);
        if (mem_ack) next_state = S_FILL;
      end
      S_FILL: begin
        fill_en    = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: begin
        refill_done_p1 = ~owner_p2;
        refill_done_p2 = owner_p2;
        next_state     = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule
